// File: rtl/jkff_bank_arbiter.sv
// Bank of 2**IDXW JK cells shared by two requesters through a round-robin arbiter.
// state | meaning
// IDLE  | waiting for a request; arbitrates and latches op/idx
// EXEC  | applies the latched JK op to the target cell
// DONE  | one-cycle ack to the granted requester
module jkff_bank_arbiter #(
  parameter int IDXW = 2,
  localparam int NCELL = 2**IDXW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [1:0]       op0,
  input  logic [IDXW-1:0]  idx0,
  output logic             ack0,
  input  logic             req1,
  input  logic [1:0]       op1,
  input  logic [IDXW-1:0]  idx1,
  output logic             ack1,
  output logic [NCELL-1:0] q,
  output logic [NCELL-1:0] qbar,
  output logic             busy,
  output logic             last_grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_op;
  logic [IDXW-1:0]   r_idx;
  logic [NCELL-1:0]  r_q;
  logic [NCELL-1:0]  r_qbar;
  logic              r_ack0;
  logic              r_ack1;
  logic              r_busy;
  logic              r_last_grant;

  logic              w_grant_vld;
  logic              w_grant_sel;
  logic [1:0]        w_op_sel;
  logic [IDXW-1:0]   w_idx_sel;
  logic [NCELL-1:0]  w_q_nxt;
  logic              w_ack0_nxt;
  logic              w_ack1_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_vld = 1'b0;
    w_grant_sel = r_last_grant;
    w_q_nxt     = r_q;
    w_ack0_nxt  = 1'b0;
    w_ack1_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        if (req0 && req1) begin
          w_grant_vld = 1'b1;
          w_grant_sel = ~r_last_grant;
        end else if (req0) begin
          w_grant_vld = 1'b1;
          w_grant_sel = 1'b0;
        end else if (req1) begin
          w_grant_vld = 1'b1;
          w_grant_sel = 1'b1;
        end
        if (w_grant_vld) w_state_nxt = EXEC;
      end
      EXEC: begin
        case (r_op)
          2'b01:   w_q_nxt[r_idx] = 1'b0;
          2'b10:   w_q_nxt[r_idx] = 1'b1;
          2'b11:   w_q_nxt[r_idx] = ~r_q[r_idx];
          default: w_q_nxt[r_idx] = r_q[r_idx];
        endcase
        w_ack0_nxt  = ~r_last_grant;
        w_ack1_nxt  = r_last_grant;
        w_state_nxt = DONE;
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_op_sel  = w_grant_sel ? op1  : op0;
  assign w_idx_sel = w_grant_sel ? idx1 : idx0;

  // last_grant doubles as the owner of the in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_op         <= 2'b00;
      r_idx        <= '0;
      r_q          <= '0;
      r_qbar       <= '1;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_busy       <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_vld) begin
        r_op         <= w_op_sel;
        r_idx        <= w_idx_sel;
        r_last_grant <= w_grant_sel;
      end
      r_q    <= w_q_nxt;
      r_qbar <= ~w_q_nxt;
      r_ack0 <= w_ack0_nxt;
      r_ack1 <= w_ack1_nxt;
      r_busy <= (w_state_nxt != IDLE);
    end
  end

  assign q          = r_q;
  assign qbar       = r_qbar;
  assign ack0       = r_ack0;
  assign ack1       = r_ack1;
  assign busy       = r_busy;
  assign last_grant = r_last_grant;

endmodule

// File: tb/tb_jkff_bank_arbiter.sv
// Directed bench for jkff_bank_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_jkff_bank_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [1:0] op0, op1;
  logic [1:0] idx0, idx1;
  logic       ack0, ack1;
  logic [3:0] q, qbar;
  logic       busy, last_grant;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jkff_bank_arbiter #(.IDXW(2)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .idx0(idx0), .ack0(ack0),
    .req1(req1), .op1(op1), .idx1(idx1), .ack1(ack1),
    .q(q), .qbar(qbar), .busy(busy), .last_grant(last_grant)
  );

  task automatic do_reset();
    rst = 1'b1; req0 = 0; req1 = 0; op0 = 0; op1 = 0; idx0 = 0; idx1 = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues one op and waits (bounded) for its ack; returns what was seen on the ack cycle.
  task automatic run_op(input bit who, input logic [1:0] op, input logic [1:0] idx,
                        output bit ok, output int lat, output logic [3:0] q_at,
                        output logic [3:0] qbar_at, output logic other_ack);
    ok = 0; lat = 0; q_at = 'x; qbar_at = 'x; other_ack = 'x;
    if (who) begin req1 = 1; op1 = op; idx1 = idx; end
    else     begin req0 = 1; op0 = op; idx0 = idx; end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if ((who ? ack1 : ack0) === 1'b1) begin
        ok = 1; lat = k; q_at = q; qbar_at = qbar; other_ack = who ? ack0 : ack1;
        break;
      end
    end
    if (who) req1 = 0; else req0 = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (q !== 4'b0000) begin n_err++; $display("FAIL reset_q got %b want 0000", q); end
    n_cmp++; if (qbar !== 4'b1111) begin n_err++; $display("FAIL reset_qbar got %b want 1111", qbar); end
    n_cmp++; if ({ack0, ack1, busy} !== 3'b000) begin n_err++; $display("FAIL reset_ack_busy got %b want 000", {ack0, ack1, busy}); end
    n_cmp++; if (last_grant !== 1'b1) begin n_err++; $display("FAIL reset_last_grant got %b want 1", last_grant); end
  endtask

  task automatic test_single();
    do_reset();
    req0 = 1; op0 = 2'b10; idx0 = 2'd2;
    @(negedge clk);
    n_cmp++; if ({busy, ack0, ack1} !== 3'b100) begin n_err++; $display("FAIL single_exec busy/ack0/ack1 got %b want 100", {busy, ack0, ack1}); end
    n_cmp++; if (q !== 4'b0000) begin n_err++; $display("FAIL single_exec_q got %b want 0000", q); end
    @(negedge clk);
    n_cmp++; if ({busy, ack0, ack1} !== 3'b110) begin n_err++; $display("FAIL single_done busy/ack0/ack1 got %b want 110", {busy, ack0, ack1}); end
    n_cmp++; if (q !== 4'b0100 || qbar !== 4'b1011) begin n_err++; $display("FAIL single_done_q got q=%b qbar=%b want 0100/1011", q, qbar); end
    req0 = 0;
    @(negedge clk);
    n_cmp++; if ({busy, ack0, ack1} !== 3'b000) begin n_err++; $display("FAIL single_idle busy/ack0/ack1 got %b want 000", {busy, ack0, ack1}); end
  endtask

  task automatic test_round_robin();
    do_reset();
    req0 = 1; op0 = 2'b10; idx0 = 2'd0;
    req1 = 1; op1 = 2'b10; idx1 = 2'd1;
    @(negedge clk);
    n_cmp++; if (last_grant !== 1'b0) begin n_err++; $display("FAIL rr_first_grant got %b want 0", last_grant); end
    @(negedge clk);
    n_cmp++; if ({ack0, ack1} !== 2'b10 || q !== 4'b0001) begin n_err++; $display("FAIL rr_ack0 got ack=%b q=%b want 10/0001", {ack0, ack1}, q); end
    req0 = 0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rr_gap_busy got %b want 0", busy); end
    @(negedge clk);
    n_cmp++; if (last_grant !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL rr_second_grant got lg=%b busy=%b want 1/1", last_grant, busy); end
    @(negedge clk);
    n_cmp++; if ({ack0, ack1} !== 2'b01 || q !== 4'b0011) begin n_err++; $display("FAIL rr_ack1 got ack=%b q=%b want 01/0011", {ack0, ack1}, q); end
    req1 = 0;
    @(negedge clk);
  endtask

  task automatic test_rr_from_zero();
    bit ok; int lat; logic [3:0] qa, qba; logic oth;
    do_reset();
    run_op(1'b0, 2'b00, 2'd0, ok, lat, qa, qba, oth);
    n_cmp++; if (!ok || qa !== 4'b0000 || last_grant !== 1'b0) begin n_err++; $display("FAIL rr0_hold got ok=%0d q=%b lg=%b want 1/0000/0", ok, qa, last_grant); end
    req0 = 1; op0 = 2'b10; idx0 = 2'd1;
    req1 = 1; op1 = 2'b10; idx1 = 2'd2;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if ({ack0, ack1} !== 2'b01 || q !== 4'b0100) begin n_err++; $display("FAIL rr0_first got ack=%b q=%b want 01/0100", {ack0, ack1}, q); end
    req1 = 0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if ({ack0, ack1} !== 2'b10 || q !== 4'b0110) begin n_err++; $display("FAIL rr0_second got ack=%b q=%b want 10/0110", {ack0, ack1}, q); end
    req0 = 0;
    @(negedge clk);
  endtask

  task automatic test_same_cell();
    do_reset();
    req0 = 1; op0 = 2'b10; idx0 = 2'd3;
    req1 = 1; op1 = 2'b11; idx1 = 2'd3;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (ack0 !== 1'b1 || q !== 4'b1000) begin n_err++; $display("FAIL same_first got ack0=%b q=%b want 1/1000", ack0, q); end
    req0 = 0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (ack1 !== 1'b1 || q !== 4'b0000 || qbar !== 4'b1111) begin n_err++; $display("FAIL same_second got ack1=%b q=%b qbar=%b want 1/0000/1111", ack1, q, qbar); end
    req1 = 0;
    @(negedge clk);
  endtask

  task automatic test_jk_table();
    logic [1:0] ops [5] = '{2'b10, 2'b00, 2'b11, 2'b01, 2'b11};
    logic       exp [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    bit ok; int lat; logic [3:0] qa, qba; logic oth;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_op(1'b1, ops[i], 2'd1, ok, lat, qa, qba, oth);
      n_cmp++;
      if (!ok || lat != 2 || oth !== 1'b0) begin
        n_err++; $display("FAIL jk_ack[%0d] got ok=%0d lat=%0d ack0=%b want 1/2/0", i, ok, lat, oth);
      end
      n_cmp++;
      if (qa !== {2'b00, exp[i], 1'b0} || qba !== ~{2'b00, exp[i], 1'b0}) begin
        n_err++; $display("FAIL jk_q[%0d] got q=%b qbar=%b want q[1]=%b only", i, qa, qba, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    req0 = 1; op0 = 2'b10; idx0 = 2'd0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0; req0 = 0;
    n_cmp++; if ({ack0, ack1, busy} !== 3'b000) begin n_err++; $display("FAIL midrst_ack_busy got %b want 000", {ack0, ack1, busy}); end
    n_cmp++; if (q !== 4'b0000 || qbar !== 4'b1111 || last_grant !== 1'b1) begin n_err++; $display("FAIL midrst_state got q=%b qbar=%b lg=%b want 0000/1111/1", q, qbar, last_grant); end
    @(negedge clk);
    n_cmp++; if (ack0 !== 1'b0 || q !== 4'b0000) begin n_err++; $display("FAIL midrst_after got ack0=%b q=%b want 0/0000", ack0, q); end
  endtask

  task automatic test_stability();
    do_reset();
    req0 = 1; op0 = 2'b10; idx0 = 2'd2;
    @(negedge clk);
    op0 = 2'b11; idx0 = 2'd0;
    @(negedge clk);
    n_cmp++; if (ack0 !== 1'b1 || q !== 4'b0100) begin n_err++; $display("FAIL stable_latched got ack0=%b q=%b want 1/0100", ack0, q); end
    req0 = 0;
    @(negedge clk);
    req1 = 1; op1 = 2'b10; idx1 = 2'd3;
    @(negedge clk);
    req1 = 0; op1 = 2'b01;
    @(negedge clk);
    n_cmp++; if (ack1 !== 1'b1 || q !== 4'b1100) begin n_err++; $display("FAIL drop_mid got ack1=%b q=%b want 1/1100", ack1, q); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || ack1 !== 1'b0) begin n_err++; $display("FAIL drop_idle got busy=%b ack1=%b want 0/0", busy, ack1); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_rr_from_zero();
    test_same_cell();
    test_jk_table();
    test_reset_mid_op();
    test_stability();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jkff_bank_arbiter.md
JKFF_BANK_ARBITER -- requirements
Module: jkff_bank_arbiter

Interface
REQ-001 SHALL have parameter IDXW, default 2, cell-index width; the bank holds NCELL = 2**IDXW JK cells.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port req0  input  1  requester 0 operation request.
REQ-005 SHALL have port op0  input  2  requester 0 JK opcode: 00 hold (J=0,K=0), 01 reset (J=0,K=1), 10 set (J=1,K=0), 11 toggle (J=1,K=1).
REQ-006 SHALL have port idx0  input  IDXW  requester 0 target cell.
REQ-007 SHALL have port ack0  output  1  requester 0 completion pulse.
REQ-008 SHALL have ports req1, op1, idx1, ack1 with the same widths and meanings for requester 1.
REQ-009 SHALL have port q  output  NCELL  cell states.
REQ-010 SHALL have port qbar  output  NCELL  bitwise complement of q.
REQ-011 SHALL have port busy  output  1  high while an operation is in flight.
REQ-012 SHALL have port last_grant  output  1  index of the most recently granted requester.

Function
REQ-013 SHALL implement a 3-state FSM: IDLE, EXEC, DONE.
REQ-014 IDLE: if neither req is high, SHALL stay in IDLE.
REQ-015 IDLE with exactly one req high: SHALL grant that requester, latch its op/idx, and go to EXEC.
REQ-016 IDLE with both req high: SHALL grant the requester not equal to last_grant (round-robin), latch its op/idx, and go to EXEC.
REQ-017 On every grant, last_grant SHALL update to the granted index on the same edge that enters EXEC.
REQ-018 EXEC: SHALL apply the latched JK op to q[idx] only, using hold/reset/set/toggle, then go to DONE; all other cells SHALL be unchanged.
REQ-019 DONE: ack of the granted requester SHALL be high for exactly this one cycle, with the other ack low; the FSM SHALL then return to IDLE.
REQ-020 busy SHALL be high in EXEC and DONE, and low in IDLE.
REQ-021 Latency: req first sampled high in IDLE cycle T gives EXEC in T+1, and updated q plus ack high in T+2; the next grant is earliest at T+3.
REQ-022 Requester protocol: req, op and idx SHALL be held stable until ack is seen, and req SHALL be dropped on the edge that samples ack.
REQ-023 The latched op/idx SHALL be used, so changes on req/op/idx during EXEC/DONE SHALL have no effect; a req dropped mid-operation SHALL still be completed and acked.
REQ-024 Both requesters targeting the same idx SHALL be serialized, and the second op SHALL act on the result of the first.
REQ-025 qbar SHALL equal ~q in every cycle, including reset.
REQ-026 q, qbar, ack0, ack1, busy and last_grant SHALL all be registered outputs.

Reset
REQ-027 With rst high at a clock edge: state SHALL go to IDLE, q to 0, qbar to all ones, ack0/ack1/busy to 0, and last_grant to 1, so requester 0 wins the first tie.
REQ-028 rst SHALL override all other inputs; reset during EXEC or DONE SHALL abandon the operation, issue no ack, and leave q = 0.
REQ-029 The first grant after rst deasserts SHALL be evaluated in the first IDLE cycle with rst low.

Verification
REQ-030 Single op: after reset, req0=1, op0=10, idx0=2 -> q=0100 and ack0=1 two cycles later, busy high for 2 cycles, ack1 stays 0.
REQ-031 Tie/round-robin: both req high, op0=10 idx0=0, op1=10 idx1=1, held across grants -> ack0 first (q=0001), then ack1 three cycles later (q=0011), with last_grant sequence 0 then 1.
REQ-032 Same-cell serialization: q=0000; req0 set idx 3 and req1 toggle idx 3 issued together -> after ack0 q[3]=1, after ack1 q[3]=0.
REQ-033 Full JK table on cell 1 via requester 1 (set, hold, toggle, reset, toggle) -> q[1] = 1,1,0,0,1 and qbar[1] = ~q[1] at every ack.
REQ-034 Reset mid-op: assert rst during EXEC of a set on idx 0 -> no ack, q=0000, qbar=1111, busy=0, and last_grant=1 on the next cycle.
REQ-035 Stability: change op0/idx0 during EXEC -> the originally latched op/idx SHALL be applied.
